// File: rtl/mips_fetch_unit.sv
// Multicycle instruction fetch: builds a 32-bit instruction from 32/WIDTH memory beats.
// Optional fetch timeout is enabled by defining FETCH_TIMEOUT_EN.
module mips_fetch_unit #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned ADRBITS = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_req,
  input  logic [ADRBITS-1:0] pc,
  input  logic               flush,
  output logic               mem_req,
  output logic [ADRBITS-1:0] mem_adr,
  input  logic [WIDTH-1:0]   mem_rdata,
  input  logic               mem_ack,
  output logic [31:0]        instr,
  output logic               instr_valid,
  output logic               busy,
  output logic               fetch_err
);

  localparam int unsigned NBEATS = 32 / WIDTH;
  localparam int unsigned BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BW-1:0] LastBeat = BW'(NBEATS - 1);

  if (WIDTH != 8 && WIDTH != 16 && WIDTH != 32) begin : g_bad_width
    $error("mips_fetch_unit: WIDTH must be 8, 16 or 32");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("mips_fetch_unit: TIMEOUT must be at least 2");
  end

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e             state_q, state_d;
  logic [ADRBITS-1:0] base_q, base_d;
  logic [BW-1:0]      beat_q, beat_d;
  logic [31:0]        shadow_q, shadow_d;
  logic [31:0]        instr_q, instr_d;
  logic               err_q, err_d;
  logic               timeout;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wait_q, wait_d;

  // Held at zero outside REQ so every REQ entry starts a fresh count.
  always_comb begin
    wait_d = '0;
    if (state_q == StReq && !mem_ack) begin
      wait_d = wait_q + 1'b1;
    end
  end

  assign timeout = (state_q == StReq) && !mem_ack && (wait_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    beat_d   = beat_q;
    shadow_d = shadow_q;
    instr_d  = instr_q;
    err_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fetch_req) begin
          state_d = StReq;
          base_d  = pc;
          beat_d  = '0;
        end
      end
      StReq: begin
        if (mem_ack) begin
          shadow_d[int'(beat_q) * WIDTH +: WIDTH] = mem_rdata;
          if (beat_q == LastBeat) begin
            state_d = StDone;
            instr_d = shadow_d;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end else if (timeout) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    // Flush overrides everything, including a completing last beat and a timeout.
    if (flush) begin
      state_d  = StIdle;
      beat_d   = '0;
      shadow_d = shadow_q;
      instr_d  = instr_q;
      err_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      base_q   <= '0;
      beat_q   <= '0;
      shadow_q <= '0;
      instr_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      beat_q   <= beat_d;
      shadow_q <= shadow_d;
      instr_q  <= instr_d;
      err_q    <= err_d;
    end
  end

  assign mem_req     = (state_q == StReq);
  assign mem_adr     = mem_req ? base_q + ADRBITS'(beat_q) : '0;
  assign instr       = instr_q;
  assign instr_valid = (state_q == StDone);
  assign busy        = (state_q != StIdle);
  assign fetch_err   = err_q;

endmodule
